lobster_mem_arbiter: RTL and testbench

Load/store scheduler that shares the single data-memory port between the two mini-instruction execution lanes of the execution manager. Accepts one memory request at a time by round-robin, holds it stable on the memory port until accepted, and for loads returns the read data as a register-file write-back with the destination register index. It sits between the mini executors' `ls_addr`/`load`/`mem_enable` outputs and the data-cache/memory interface.

---
 rtl/lobster_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_lobster_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lobster_mem_arbiter.sv
// Round-robin load/store scheduler sharing one data-memory port between two lanes.
// Accepts one request at a time, holds it on the port until accepted, and returns load data as a write-back.
module lobster_mem_arbiter #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_load,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    input  logic [2*7-1:0]          req_rd,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_load,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    wb_valid,
    output logic [6:0]              wb_select,
    output logic [DATA_WIDTH-1:0]   wb_value,
    output logic                    wb_lane,
    output logic                    busy,
    output logic                    err_spurious
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    rr_ptr_reg;
    logic                    load_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [6:0]              rd_reg;
    logic                    lane_reg;
    logic                    wb_valid_reg;
    logic [6:0]              wb_select_reg;
    logic [DATA_WIDTH-1:0]   wb_value_reg;
    logic                    wb_lane_reg;
    logic                    err_reg;

    logic [ADDR_WIDTH-1:0]   lane_addr  [2];
    logic [DATA_WIDTH-1:0]   lane_wdata [2];
    logic [6:0]              lane_rd    [2];
    logic [1:0]              grant;
    logic                    grant_lane;
    logic                    accept;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign lane_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign lane_rd[gi]    = req_rd[gi*7 +: 7];
        end
    endgenerate

    // Grant is gated by rst so nothing is offered while reset is held.
    always_comb begin
        grant      = 2'b00;
        grant_lane = 1'b0;
        if (state_reg == IDLE && !rst) begin
            case (req_valid)
                2'b01:   begin grant = 2'b01; grant_lane = 1'b0; end
                2'b10:   begin grant = 2'b10; grant_lane = 1'b1; end
                2'b11:   begin
                    grant_lane = rr_ptr_reg;
                    grant      = rr_ptr_reg ? 2'b10 : 2'b01;
                end
                default: begin grant = 2'b00; grant_lane = 1'b0; end
            endcase
        end
    end

    assign accept = |(req_valid & grant);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept) state_next = ISSUE;
            ISSUE:     if (mem_ready) state_next = load_reg ? WAIT_RESP : IDLE;
            WAIT_RESP: if (mem_rvalid) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            load_reg      <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rd_reg        <= '0;
            lane_reg      <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_select_reg <= '0;
            wb_value_reg  <= '0;
            wb_lane_reg   <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= 1'b0;
            if (accept) begin
                load_reg   <= req_load[grant_lane];
                addr_reg   <= lane_addr[grant_lane];
                wdata_reg  <= lane_wdata[grant_lane];
                rd_reg     <= lane_rd[grant_lane];
                lane_reg   <= grant_lane;
                rr_ptr_reg <= ~grant_lane;
            end
            // Loads to REG_ZERO still read memory but leave the write-back outputs untouched.
            if (state_reg == WAIT_RESP && mem_rvalid && rd_reg != 7'd0) begin
                wb_valid_reg  <= 1'b1;
                wb_select_reg <= rd_reg;
                wb_value_reg  <= mem_rdata;
                wb_lane_reg   <= lane_reg;
            end
            if (mem_rvalid && state_reg != WAIT_RESP)
                err_reg <= 1'b1;
        end
    end

    assign req_ready    = grant;
    assign mem_valid    = (state_reg == ISSUE);
    assign mem_load     = load_reg;
    assign mem_addr     = addr_reg;
    assign mem_wdata    = wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_select    = wb_select_reg;
    assign wb_value     = wb_value_reg;
    assign wb_lane      = wb_lane_reg;
    assign busy         = (state_reg != IDLE);
    assign err_spurious = err_reg;
endmodule

// File: tb/tb_lobster_mem_arbiter.sv
// Directed bench for lobster_mem_arbiter: stores, loads, round-robin, REG_ZERO, spurious responses, mid-flight reset.
module tb_lobster_mem_arbiter;
    localparam int AW = 36;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_load;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [6:0]    rd0, rd1;
    logic          mem_valid, mem_ready, mem_load, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          wb_valid, wb_lane, busy, err_spurious;
    logic [6:0]    wb_select;
    logic [DW-1:0] wb_value;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lobster_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_addr({addr1, addr0}), .req_wdata({wdata1, wdata0}), .req_rd({rd1, rd0}),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_load(mem_load),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_select(wb_select), .wb_value(wb_value), .wb_lane(wb_lane),
        .busy(busy), .err_spurious(err_spurious)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0]    exp_grant;
    logic [AW-1:0] exp_addr;

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_load = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; rd0 = '0; rd1 = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst_req_ready", 128'(req_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_mem_valid", 128'(mem_valid), 128'd0);
        check("rst_wb_valid", 128'(wb_valid), 128'd0);
        check("rst_err", 128'(err_spurious), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // Lane 0 store
        req_valid = 2'b01; req_load = 2'b00; addr0 = 36'h100; wdata0 = 128'hAB; mem_ready = 1'b1;
        #1 check("st_req_ready", 128'(req_ready), 128'b01);
        tick();
        req_valid = 2'b00;
        check("st_mem_valid", 128'(mem_valid), 128'd1);
        check("st_mem_addr", 128'(mem_addr), 128'h100);
        check("st_mem_wdata", mem_wdata, 128'hAB);
        check("st_mem_load", 128'(mem_load), 128'd0);
        check("st_busy", 128'(busy), 128'd1);
        check("st_req_ready_busy", 128'(req_ready), 128'd0);
        tick();
        check("st_mem_valid_fall", 128'(mem_valid), 128'd0);
        check("st_busy_fall", 128'(busy), 128'd0);
        check("st_no_wb", 128'(wb_valid), 128'd0);

        // Lane 1 load, late mem_ready
        mem_ready = 1'b0;
        req_valid = 2'b10; req_load = 2'b10; addr1 = 36'h40; rd1 = 7'd5;
        #1 check("ld_req_ready", 128'(req_ready), 128'b10);
        tick();
        req_valid = 2'b00;
        check("ld_mem_valid", 128'(mem_valid), 128'd1);
        check("ld_mem_load", 128'(mem_load), 128'd1);
        check("ld_addr_c1", 128'(mem_addr), 128'h40);
        tick();
        check("ld_addr_c2", 128'(mem_addr), 128'h40);
        check("ld_valid_c2", 128'(mem_valid), 128'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("ld_wait_mem_valid", 128'(mem_valid), 128'd0);
        check("ld_wait_busy", 128'(busy), 128'd1);
        tick(); tick();
        mem_rvalid = 1'b1; mem_rdata = 128'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        check("ld_wb_valid", 128'(wb_valid), 128'd1);
        check("ld_wb_select", 128'(wb_select), 128'd5);
        check("ld_wb_value", wb_value, 128'hDEAD);
        check("ld_wb_lane", 128'(wb_lane), 128'd1);
        check("ld_busy_done", 128'(busy), 128'd0);
        tick();
        check("ld_wb_pulse", 128'(wb_valid), 128'd0);
        check("ld_wb_hold", wb_value, 128'hDEAD);
        check("ld_err_clean", 128'(err_spurious), 128'd0);

        // Round-robin from reset, both lanes storing continuously
        do_reset();
        req_valid = 2'b11; req_load = 2'b00; addr0 = 36'h200; addr1 = 36'h300;
        wdata0 = 128'h11; wdata1 = 128'h22; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (i % 2 == 0) ? 36'h200 : 36'h300;
            #1 check($sformatf("rr_grant%0d", i), 128'(req_ready), 128'(exp_grant));
            tick();
            check($sformatf("rr_addr%0d", i), 128'(mem_addr), 128'(exp_addr));
            check($sformatf("rr_valid%0d", i), 128'(mem_valid), 128'd1);
            tick();
            check($sformatf("rr_idle%0d", i), 128'(mem_valid), 128'd0);
        end
        req_valid = 2'b00;

        // Load to REG_ZERO
        req_valid = 2'b01; req_load = 2'b01; addr0 = 36'h80; rd0 = 7'd0;
        tick();
        req_valid = 2'b00;
        check("z_mem_load", 128'(mem_load), 128'd1);
        check("z_mem_addr", 128'(mem_addr), 128'h80);
        tick();
        check("z_busy_wait", 128'(busy), 128'd1);
        mem_rvalid = 1'b1; mem_rdata = 128'h1;
        tick();
        mem_rvalid = 1'b0;
        check("z_no_wb", 128'(wb_valid), 128'd0);
        check("z_wb_value_hold", wb_value, 128'd0);
        check("z_busy_done", 128'(busy), 128'd0);
        check("z_err_clean", 128'(err_spurious), 128'd0);

        // Spurious rvalid in IDLE
        mem_rvalid = 1'b1; mem_rdata = 128'h77;
        tick();
        mem_rvalid = 1'b0;
        check("sp_no_wb", 128'(wb_valid), 128'd0);
        check("sp_err", 128'(err_spurious), 128'd1);
        tick(); tick();
        check("sp_err_sticky", 128'(err_spurious), 128'd1);

        // Reset while in WAIT_RESP
        do_reset();
        check("rr2_err_cleared", 128'(err_spurious), 128'd0);
        req_valid = 2'b01; req_load = 2'b01; addr0 = 36'h10; rd0 = 7'd3; mem_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        tick();
        check("mr_busy_wait", 128'(busy), 128'd1);
        check("mr_addr", 128'(mem_addr), 128'h10);
        rst = 1'b1; req_valid = 2'b11;
        #1;
        check("mr_busy_async", 128'(busy), 128'd0);
        check("mr_req_ready", 128'(req_ready), 128'd0);
        check("mr_mem_addr", 128'(mem_addr), 128'd0);
        tick();
        rst = 1'b0; req_valid = 2'b00;
        mem_rvalid = 1'b1; mem_rdata = 128'h55;
        tick();
        mem_rvalid = 1'b0;
        check("mr_no_wb", 128'(wb_valid), 128'd0);
        check("mr_wb_value", wb_value, 128'd0);
        check("mr_wb_select", 128'(wb_select), 128'd0);
        check("mr_mem_valid", 128'(mem_valid), 128'd0);
        check("mr_err", 128'(err_spurious), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
